// File: rtl/two_is_to_four_if.sv
// Bundle of the decoder's select inputs, decoded lines, inverted inputs and
// per-line hit counters. The producer of a/b/en/clr uses the master view;
// the decoder itself uses the slave view.
interface two_is_to_four_if #(
   parameter int CNT_W = 8
);

   // Select and control inputs to the decoder
   logic             en;
   logic             clr;
   logic             a;
   logic             b;

   // Combinational inverted inputs
   logic             nota;
   logic             notb;

   // Registered one-hot decode lines
   logic             ynot;
   logic             yone;
   logic             ytwo;
   logic             ythree;

   // Per-line saturating hit counters
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   logic [CNT_W-1:0] cnt2;
   logic [CNT_W-1:0] cnt3;

   modport master (
      output en, clr, a, b,
      input  nota, notb,
      input  ynot, yone, ytwo, ythree,
      input  cnt0, cnt1, cnt2, cnt3
   );

   modport slave (
      input  en, clr, a, b,
      output nota, notb,
      output ynot, yone, ytwo, ythree,
      output cnt0, cnt1, cnt2, cnt3
   );

endinterface

// File: rtl/two_is_to_four.sv
// Registered 2-to-4 line decoder. {a,b} selects one of four one-hot lines,
// registered on the rising edge while en is high; all lines drop to zero
// while en is low. Each line owns a saturating hit counter that counts
// enabled cycles selecting it; clr zeroes every counter and wins over a
// same-cycle increment. nota/notb are plain inverters with no clock path.
module two_is_to_four #(
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   two_is_to_four_if.slave dec
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       sel;
   logic [3:0]       y_d;
   logic [3:0]       y_q;
   logic [CNT_W-1:0] cnt_q [4];

   assign sel = {dec.a, dec.b};

   // Inverters follow the inputs at all times, including during reset.
   assign dec.nota = ~dec.a;
   assign dec.notb = ~dec.b;

   // Next-state decode: one-hot on sel when enabled, all-zero otherwise.
   always_comb begin
      y_d = 4'b0000;
      if (dec.en) begin
         y_d[sel] = 1'b1;
      end
   end

   // Decode lines register; async reset forces every line low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= 4'b0000;
      end else begin
         y_q <= y_d;
      end
   end

   // Hit counters: clr has priority, otherwise the selected line counts up
   // on an enabled edge and sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else if (dec.clr) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (dec.en && (sel == 2'(k)) && (cnt_q[k] != CNT_MAX)) begin
               cnt_q[k] <= cnt_q[k] + CNT_ONE;
            end
         end
      end
   end

   assign dec.ynot   = y_q[0];
   assign dec.yone   = y_q[1];
   assign dec.ytwo   = y_q[2];
   assign dec.ythree = y_q[3];

   assign dec.cnt0 = cnt_q[0];
   assign dec.cnt1 = cnt_q[1];
   assign dec.cnt2 = cnt_q[2];
   assign dec.cnt3 = cnt_q[3];

endmodule

// File: tb/tb_two_is_to_four.sv
// Directed bench for two_is_to_four: reset behaviour, full select sweep,
// enable gating, counter saturation, clear priority and mid-run reset.
module tb_two_is_to_four;

   localparam int CNT_W = 8;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   two_is_to_four_if #(.CNT_W(CNT_W)) dec_if ();

   two_is_to_four #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dec   (dec_if)
   );

   // Clock: 10 time-unit period, first rising edge at t=5.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed lines packed as {ythree, ytwo, yone, ynot}.
   function automatic logic [3:0] y_obs();
      return {dec_if.ythree, dec_if.ytwo, dec_if.yone, dec_if.ynot};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive inputs away from the edge, take one rising edge, settle 1 unit.
   task automatic cycle(input logic e, input logic c, input logic aa, input logic bb);
      dec_if.en  = e;
      dec_if.clr = c;
      dec_if.a   = aa;
      dec_if.b   = bb;
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnts(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
      check({tag, ".cnt0"}, 32'(dec_if.cnt0), 32'(e0));
      check({tag, ".cnt1"}, 32'(dec_if.cnt1), 32'(e1));
      check({tag, ".cnt2"}, 32'(dec_if.cnt2), 32'(e2));
      check({tag, ".cnt3"}, 32'(dec_if.cnt3), 32'(e3));
   endtask

   initial begin
      logic [3:0] sweep_y [4];
      logic [1:0] sweep_n [4];
      int         exp_c1;

      sweep_y[0] = 4'b0001; sweep_n[0] = 2'b11;
      sweep_y[1] = 4'b0010; sweep_n[1] = 2'b10;
      sweep_y[2] = 4'b0100; sweep_n[2] = 2'b01;
      sweep_y[3] = 4'b1000; sweep_n[3] = 2'b00;

      n_checks = 0;
      n_fail   = 0;

      // Reset asserted with a=1,b=1,en=1, checked before any clock edge.
      rst_n      = 1'b1;
      dec_if.en  = 1'b1;
      dec_if.clr = 1'b0;
      dec_if.a   = 1'b1;
      dec_if.b   = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst.y", 32'(y_obs()), 32'h0);
      check_cnts("rst", 8'd0, 8'd0, 8'd0, 8'd0);
      check("rst.nota", 32'(dec_if.nota), 32'd0);
      check("rst.notb", 32'(dec_if.notb), 32'd0);
      // Inverters keep following the inputs while reset is held.
      dec_if.a = 1'b0;
      #1;
      check("rst.nota_follow", 32'(dec_if.nota), 32'd1);
      @(posedge clk);
      #1;
      check("rst.y_held", 32'(y_obs()), 32'h0);
      rst_n = 1'b1;

      // Full sweep 00,01,10,11.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, i[1], i[0]);
         check($sformatf("sweep%0d.y", i), 32'(y_obs()), 32'(sweep_y[i]));
         check($sformatf("sweep%0d.not", i), 32'({dec_if.nota, dec_if.notb}), 32'(sweep_n[i]));
      end
      check_cnts("sweep", 8'd1, 8'd1, 8'd1, 8'd1);

      // Enable gating: en=0, sel=10.
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check("gate.y", 32'(y_obs()), 32'h0);
      check_cnts("gate", 8'd1, 8'd1, 8'd1, 8'd1);

      // Clear with en=1 sel=00: counters zero, decode still happens.
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("clr0.y", 32'(y_obs()), 32'(4'b0001));
      check_cnts("clr0", 8'd0, 8'd0, 8'd0, 8'd0);

      // Saturation: hold sel=01 for 300 enabled cycles.
      for (int i = 1; i <= 300; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b1);
         exp_c1 = (i > 255) ? 255 : i;
         check($sformatf("sat%0d.yone", i), 32'(dec_if.yone), 32'd1);
         check($sformatf("sat%0d.cnt1", i), 32'(dec_if.cnt1), 32'(exp_c1));
      end
      check_cnts("sat", 8'd0, 8'd255, 8'd0, 8'd0);

      // Clear priority: build cnt3=5, then clr with en=1 sel=11.
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check_cnts("pre", 8'd0, 8'd0, 8'd0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b1);
      end
      check("cp.cnt3_5", 32'(dec_if.cnt3), 32'd5);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      check("cp.y", 32'(y_obs()), 32'(4'b1000));
      check_cnts("cp", 8'd0, 8'd0, 8'd0, 8'd0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      check("cp.after", 32'(dec_if.cnt3), 32'd1);

      // Mid-run reset: cnt0 to 3, pulse rst_n between edges.
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("mid.cnt0_3", 32'(dec_if.cnt0), 32'd3);
      check("mid.y_pre", 32'(y_obs()), 32'(4'b0001));
      #1 rst_n = 1'b0;
      #1;
      check("mid.y", 32'(y_obs()), 32'h0);
      check_cnts("mid", 8'd0, 8'd0, 8'd0, 8'd0);
      #1 rst_n = 1'b1;
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
      check("mid.post_y", 32'(y_obs()), 32'(4'b0100));
      check_cnts("mid.post", 8'd0, 8'd0, 8'd1, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
